framed_uart_io: RTL and testbench
=================================

# framed_uart_io

Parametrised host-to-DUT frame interface wrapping the `UART` byte engine. It generalises the fixed-width control/data port in four ways:
- independent receive and transmit widths;
- sync-byte framing with an XOR checksum;
- an inter-byte timeout that resynchronises on a broken frame;
- a double-buffered receive path, so the host can stream the next frame while the DUT still holds the previous one.

It sits between the board USB/UART bridge pins and the DUT.

## Interface
Parameters:
- `RX_BYTES`, 4: data bytes per host→DUT frame; ≥1.
- `TX_BYTES`, 4: data bytes per DUT→host frame; ≥1.
- `CLOCK_SCALE`, 10: passed to `UART`; the resulting clock must be 4× the baud rate.
- `TIMEOUT_CYCLES`, 1000000: maximum masterClock cycles allowed between bytes inside a frame; ≥2.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `masterClock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `rx` in 1: UART receive line.
- `tx` out 1: UART transmit line.
- `control` out 8: control byte of the held frame.
- `inputData` out RX_BYTES*8: data of the held frame; first received byte sits in the MSBs.
- `dataReceived` out 1: held frame valid.
- `clearDR` in 1: DUT acknowledge; frees the holding register.
- `status` in 8: status byte to send.
- `outputData` in TX_BYTES*8: data to send; MSB byte first.
- `transmit` in 1: request frame transmission.
- `transmitting` out 1: transmit frame in progress.
- `frameError` out 1: one-cycle pulse on a checksum mismatch or timeout.
- `overrun` out 1: one-cycle pulse when a valid frame is dropped.

## Operation
- **Reset.** While `reset`=0, all outputs are 0, except `tx`, which is 1 (idle). Both FSMs go to their idle state and all counters clear. Reset asserted mid-frame discards the partial frame immediately.
- **Host frame (RX_BYTES+3 bytes).** SYNC, control, data bytes in order from MSB to LSB, then checksum. The checksum is the XOR of control and all data bytes.
- **DUT frame (TX_BYTES+3 bytes).** SYNC, status, data bytes in order from MSB to LSB, then checksum. The checksum is the XOR of status and all data bytes.
- **Byte strobe.** `byteStb` is a one-cycle pulse on the rising edge of UART `dataReceived`. UART `clearDR` is driven high from the strobe until UART `dataReceived` falls.
- **RX FSM states:**
  - HUNT: discard any byte other than SYNC_BYTE; on SYNC_BYTE go to CTRL.
  - CTRL: capture the control byte; clear the running XOR and load it with the control byte; go to DATA.
  - DATA: shift each byte in and XOR it into the running checksum; after RX_BYTES bytes go to CSUM.
  - CSUM: if the byte equals the running XOR, commit; otherwise pulse `frameError`. Return to HUNT in both cases.
- **Commit rules:**
  - Holding register empty, or `clearDR`=1 in the same cycle: the staging register is copied to `control`/`inputData`, and `dataReceived` is 1 from the next cycle.
  - Holding register full and `clearDR`=0: the frame is dropped, `overrun` pulses, and the held data is unchanged.
- **Receive acknowledge.** `clearDR`=1 with no commit in that cycle clears `dataReceived` on the next edge. The RX FSM never stalls on the holding register.
- **Timeout.** In CTRL, DATA and CSUM, a counter resets on each `byteStb`. When it reaches TIMEOUT_CYCLES−1, `frameError` pulses and the FSM goes to HUNT. HUNT has no timeout.
- **TX FSM states:**
  - IDLE: when `transmit`=1, latch `status` and `outputData` on that edge, set `transmitting`, and go to LOAD.
  - LOAD: present the next byte and assert `txRequest`.
  - WAIT_ACT: hold `txRequest` until UART `txActive`=1, then drop `txRequest`.
  - WAIT_DONE: when `txActive`=0, go back to LOAD if bytes remain, otherwise go to DONE.
  - DONE: when `transmit`=0, return to IDLE and clear `transmitting`.
- **Transmit edge rule.** A `transmit` held high produces exactly one frame. Input changes while `transmitting`=1 are ignored.
- **Widths.** Byte counters are `$clog2(max(RX_BYTES,TX_BYTES)+3)` bits wide. The timeout counter is `$clog2(TIMEOUT_CYCLES)` bits wide.

## Timing
- `byteStb` follows UART `dataReceived` rising by 1 cycle.
- For the checksum byte, the commit happens on the `byteStb` cycle, and `dataReceived`, `control` and `inputData` update on the next edge (latency 2 cycles from UART `dataReceived`).
- `frameError` and `overrun` are high for exactly one cycle.
- `transmitting` rises 1 cycle after `transmit` is sampled high.
- The first `txRequest` is asserted 2 cycles after `transmit` is sampled high.
- Bytes are sent back-to-back, separated only by the UART handshake.
- `transmitting` falls 1 cycle after DONE sees both `transmit`=0 and `txActive`=0.

## Structure
- **Shared package `uart_frame_pkg`:**
  - RX state encoding {HUNT, CTRL, DATA, CSUM};
  - TX state encoding {IDLE, LOAD, WAIT_ACT, WAIT_DONE, DONE};
  - default SYNC_BYTE;
  - an 8-bit XOR-accumulate function.
- **Sub-module:** a single instance of the existing `UART`. The RX and TX FSMs stay in `framed_uart_io`.

## Test plan
All scenarios use RX_BYTES=2, TX_BYTES=2, TIMEOUT_CYCLES=2000.
- **Valid frame.** Host sends A5 03 12 34 25 → `control`=03, `inputData`=1234, `dataReceived`=1; `frameError` stays 0.
- **Noise and bad checksum.** Host sends 00 FF, then A5 03 12 34 00 → leading bytes ignored; `frameError` pulses once; `dataReceived` stays 0. A following A5 01 00 00 01 is accepted.
- **Timeout.** Host sends A5 03 12, idles 2000 cycles, then sends A5 07 AA 55 F8 → `frameError` pulses once; then `control`=07, `inputData`=AA55.
- **Double buffering.** Two valid frames sent with no `clearDR` → first frame held and `overrun` pulses on the second. Repeat with `clearDR` asserted in the second frame's commit cycle → second frame is held and `overrun` stays 0.
- **Transmit.** `status`=80, `outputData`=BEEF, `transmit` held high for 50k cycles → exactly one frame A5 80 BE EF D1 on `tx`; `transmitting` drops only after `transmit`=0.
- **Reset mid-frame.** `reset`=0 mid-frame during both transmit and receive → `tx`=1 and all outputs 0 immediately; the next frame is received correctly.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the framed UART host interface.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_CTRL,
    RX_DATA,
    RX_CSUM
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_ACT,
    TX_WAIT_DONE,
    TX_DONE
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Running frame checksum: XOR of every payload byte.
  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/UART.sv
// Byte-level UART engine: 8N1, one bit period = 4*CLOCK_SCALE clock cycles.
// rxData/dataReceived hold the last byte until clearDR; txRequest starts a byte.
module UART #(
  parameter int CLOCK_SCALE = 10
) (
  input  logic       masterClock,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rxData,
  output logic       dataReceived,
  input  logic       clearDR,
  input  logic [7:0] txData,
  input  logic       txRequest,
  output logic       txActive
);

  localparam int BIT_CYCLES  = 4 * CLOCK_SCALE;
  localparam int HALF_CYCLES = 2 * CLOCK_SCALE;
  localparam int TW          = $clog2(BIT_CYCLES);

  logic          rx_meta, rx_sync, rx_busy;
  logic [3:0]    rx_bit;
  logic [TW-1:0] rx_timer;
  logic [7:0]    rx_shift;

  logic [3:0]    tx_bit;
  logic [TW-1:0] tx_timer;
  logic [8:0]    tx_shift;

  // Receiver: synchronise rx, find the start bit, then sample each bit mid-period.
  always_ff @(posedge masterClock or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    if (!reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_busy      <= 1'b0;
      rx_bit       <= '0;
      rx_timer     <= '0;
      rx_shift     <= '0;
      rxData       <= '0;
      dataReceived <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      if (clearDR) dataReceived <= 1'b0;
      if (!rx_busy) begin
        if (!rx_sync) begin
          rx_busy  <= 1'b1;
          rx_timer <= TW'(HALF_CYCLES - 1);
          rx_bit   <= '0;
        end
      end else if (rx_timer != '0) begin
        rx_timer <= rx_timer - TW'(1);
      end else begin
        rx_timer <= TW'(BIT_CYCLES - 1);
        if (rx_bit == 4'd0) begin
          // A start bit that is high again at mid-period was a glitch.
          if (rx_sync) rx_busy <= 1'b0;
          else         rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_sync) begin
            rxData       <= rx_shift;
            dataReceived <= 1'b1;
          end
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end
    end
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit; txActive spans the whole byte.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b1;
      txActive <= 1'b0;
      tx_bit   <= '0;
      tx_timer <= '0;
      tx_shift <= '0;
    end else if (!txActive) begin
      if (txRequest) begin
        txActive <= 1'b1;
        tx       <= 1'b0;
        tx_shift <= {1'b1, txData};
        tx_bit   <= '0;
        tx_timer <= TW'(BIT_CYCLES - 1);
      end
    end else if (tx_timer != '0) begin
      tx_timer <= tx_timer - TW'(1);
    end else begin
      tx_timer <= TW'(BIT_CYCLES - 1);
      if (tx_bit == 4'd9) begin
        txActive <= 1'b0;
      end else begin
        tx       <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bit   <= tx_bit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/framed_uart_io.sv
// Framed host<->DUT link over UART: sync byte, payload, XOR checksum,
// inter-byte timeout and a double-buffered receive holding register.
module framed_uart_io
  import uart_frame_pkg::*;
#(
  parameter int         RX_BYTES       = 4,
  parameter int         TX_BYTES       = 4,
  parameter int         CLOCK_SCALE    = 10,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic                  masterClock,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  tx,
  output logic [7:0]            control,
  output logic [RX_BYTES*8-1:0] inputData,
  output logic                  dataReceived,
  input  logic                  clearDR,
  input  logic [7:0]            status,
  input  logic [TX_BYTES*8-1:0] outputData,
  input  logic                  transmit,
  output logic                  transmitting,
  output logic                  frameError,
  output logic                  overrun
);

  localparam int RX_W      = RX_BYTES * 8;
  localparam int TX_W      = TX_BYTES * 8;
  localparam int MAX_BYTES = (RX_BYTES > TX_BYTES) ? RX_BYTES : TX_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 3);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_BYTES + 2);

  logic [7:0] rx_byte, tx_byte;
  logic       uart_dr, uart_clear, dr_q, byte_stb, tx_req, tx_active;

  UART #(.CLOCK_SCALE(CLOCK_SCALE)) u_uart (
    .masterClock  (masterClock),
    .reset        (reset),
    .rx           (rx),
    .tx           (tx),
    .rxData       (rx_byte),
    .dataReceived (uart_dr),
    .clearDR      (uart_clear),
    .txData       (tx_byte),
    .txRequest    (tx_req),
    .txActive     (tx_active)
  );

  // One-cycle strobe per received byte; acknowledge the UART until it drops dataReceived.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      dr_q       <= 1'b0;
      byte_stb   <= 1'b0;
      uart_clear <= 1'b0;
    end else begin
      dr_q     <= uart_dr;
      byte_stb <= uart_dr & ~dr_q;
      if (byte_stb)     uart_clear <= 1'b1;
      else if (!uart_dr) uart_clear <= 1'b0;
    end
  end

  // ---------------- receive path ----------------
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [TMO_W-1:0] tmo;
  logic [7:0]       ctrl_stage, rx_csum;
  logic [RX_W-1:0]  data_stage, data_shifted;
  logic             cap_ctrl, shift_data, commit, drop, bad_frame, tmo_hit;

  assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // RX state register.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) rx_state <= RX_HUNT;
    else        rx_state <= rx_next;
  end

  // RX next state and per-cycle datapath controls.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rx_next    = rx_state;
    cap_ctrl   = 1'b0;
    shift_data = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    bad_frame  = 1'b0;
    case (rx_state)
      RX_HUNT: if (byte_stb && rx_byte == SYNC_BYTE) rx_next = RX_CTRL;
      RX_CTRL: begin
        if (byte_stb) begin
          cap_ctrl = 1'b1;
          rx_next  = RX_DATA;
        end else if (tmo_hit) begin
          bad_frame = 1'b1;
          rx_next   = RX_HUNT;
        end
      end
      RX_DATA: begin
        if (byte_stb) begin
          shift_data = 1'b1;
          if (rx_cnt == CNT_W'(RX_BYTES - 1)) rx_next = RX_CSUM;
        end else if (tmo_hit) begin
          bad_frame = 1'b1;
          rx_next   = RX_HUNT;
        end
      end
      RX_CSUM: begin
        if (byte_stb) begin
          rx_next = RX_HUNT;
          if (rx_byte != rx_csum)             bad_frame = 1'b1;
          else if (!dataReceived || clearDR)  commit    = 1'b1;
          else                                drop      = 1'b1;
        end else if (tmo_hit) begin
          bad_frame = 1'b1;
          rx_next   = RX_HUNT;
        end
      end
      default: rx_next = RX_HUNT;
    endcase
  end

  // Data bytes enter at the LSB so the first one ends up in the MSBs.
  always_comb begin
    data_shifted      = data_stage << 8;
    data_shifted[7:0] = rx_byte;
  end

  // RX staging, checksum, timeout counter and holding register.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      tmo          <= '0;
      rx_cnt       <= '0;
      ctrl_stage   <= '0;
      rx_csum      <= '0;
      data_stage   <= '0;
      control      <= '0;
      inputData    <= '0;
      dataReceived <= 1'b0;
      frameError   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frameError <= bad_frame;
      overrun    <= drop;
      if (rx_next == RX_HUNT || byte_stb) tmo <= '0;
      else                                tmo <= tmo + TMO_W'(1);
      if (cap_ctrl) begin
        ctrl_stage <= rx_byte;
        rx_csum    <= xor_acc(8'h00, rx_byte);
        rx_cnt     <= '0;
      end
      if (shift_data) begin
        data_stage <= data_shifted;
        rx_csum    <= xor_acc(rx_csum, rx_byte);
        rx_cnt     <= rx_cnt + CNT_W'(1);
      end
      if (commit) begin
        control      <= ctrl_stage;
        inputData    <= data_stage;
        dataReceived <= 1'b1;
      end else if (clearDR) begin
        dataReceived <= 1'b0;
      end
    end
  end

  // ---------------- transmit path ----------------
  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_idx;
  logic [7:0]       status_q, tx_csum, tx_csum_in, tx_byte_next;
  logic [TX_W-1:0]  tx_shift;
  logic             latch_tx, load_byte, drop_req, next_byte, finish_tx, tx_is_data;

  // TX state register.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next state: one frame per transmit request, handshaking each byte with the UART.
  always_comb begin
    tx_next   = tx_state;
    latch_tx  = 1'b0;
    load_byte = 1'b0;
    drop_req  = 1'b0;
    next_byte = 1'b0;
    finish_tx = 1'b0;
    case (tx_state)
      TX_IDLE: if (transmit) begin
        latch_tx = 1'b1;
        tx_next  = TX_LOAD;
      end
      TX_LOAD: begin
        load_byte = 1'b1;
        tx_next   = TX_WAIT_ACT;
      end
      TX_WAIT_ACT: if (tx_active) begin
        drop_req = 1'b1;
        tx_next  = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: if (!tx_active) begin
        if (tx_idx == TX_LAST) tx_next = TX_DONE;
        else begin
          next_byte = 1'b1;
          tx_next   = TX_LOAD;
        end
      end
      TX_DONE: if (!transmit && !tx_active) begin
        finish_tx = 1'b1;
        tx_next   = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // Checksum of the frame about to be latched.
  always_comb begin
    tx_csum_in = status;
    for (int i = 0; i < TX_BYTES; i++) tx_csum_in = xor_acc(tx_csum_in, outputData[i*8 +: 8]);
  end

  // Byte to present: sync, status, data MSB first, checksum.
  always_comb begin
    tx_is_data   = (tx_idx > CNT_W'(1)) && (tx_idx < TX_LAST);
    tx_byte_next = tx_shift[TX_W-1 -: 8];
    if (tx_idx == '0)                tx_byte_next = SYNC_BYTE;
    else if (tx_idx == CNT_W'(1))    tx_byte_next = status_q;
    else if (tx_idx == TX_LAST)      tx_byte_next = tx_csum;
  end

  // TX frame latch, byte sequencing and UART request.
  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      status_q     <= '0;
      tx_shift     <= '0;
      tx_csum      <= '0;
      tx_idx       <= '0;
      tx_byte      <= '0;
      tx_req       <= 1'b0;
      transmitting <= 1'b0;
    end else begin
      if (latch_tx) begin
        status_q     <= status;
        tx_shift     <= outputData;
        tx_csum      <= tx_csum_in;
        tx_idx       <= '0;
        transmitting <= 1'b1;
      end
      if (load_byte) begin
        tx_req  <= 1'b1;
        tx_byte <= tx_byte_next;
        if (tx_is_data) tx_shift <= tx_shift << 8;
      end
      if (drop_req)  tx_req       <= 1'b0;
      if (next_byte) tx_idx       <= tx_idx + CNT_W'(1);
      if (finish_tx) transmitting <= 1'b0;
    end
  end

endmodule

// File: tb/tb_framed_uart_io.sv
// Scoreboard bench for framed_uart_io: directed host frames and one DUT frame,
// expected events queued at stimulus time and consumed by independent monitors.
`timescale 1ns/1ps
module tb_framed_uart_io;

  localparam int RX_BYTES       = 2;
  localparam int TX_BYTES       = 2;
  localparam int CLOCK_SCALE    = 10;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int BIT_CYCLES     = 4 * CLOCK_SCALE;

  logic                  masterClock, reset, rx, tx;
  logic [7:0]            control, status;
  logic [RX_BYTES*8-1:0] inputData;
  logic [TX_BYTES*8-1:0] outputData;
  logic                  dataReceived, clearDR, transmit, transmitting, frameError, overrun;

  framed_uart_io #(
    .RX_BYTES       (RX_BYTES),
    .TX_BYTES       (TX_BYTES),
    .CLOCK_SCALE    (CLOCK_SCALE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .masterClock  (masterClock),
    .reset        (reset),
    .rx           (rx),
    .tx           (tx),
    .control      (control),
    .inputData    (inputData),
    .dataReceived (dataReceived),
    .clearDR      (clearDR),
    .status       (status),
    .outputData   (outputData),
    .transmit     (transmit),
    .transmitting (transmitting),
    .frameError   (frameError),
    .overrun      (overrun)
  );

  initial masterClock = 1'b0;
  always #5 masterClock = ~masterClock;

  typedef enum int {EV_FRAME, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  ctrl;
    logic [15:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_tx[$];
  int         checks = 0;
  int         errors = 0;
  bit         tx_mon_en = 1'b1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(ev_kind_t k, logic [7:0] c, logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.ctrl = c;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic take_event(ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_FRAME && e.kind == EV_FRAME) begin
        check("control", control, e.ctrl);
        check("inputData", inputData, e.data);
      end
    end
  endtask

  // Receive-side monitor: frame commits, error and overrun pulses.
  initial begin : rx_monitor
    logic        prev_dr, prev_fe, prev_ov;
    logic [23:0] prev_held;
    prev_dr = 1'b0; prev_fe = 1'b0; prev_ov = 1'b0; prev_held = '0;
    forever begin
      @(negedge masterClock);
      if (reset) begin
        if (dataReceived && (!prev_dr || {control, inputData} != prev_held)) take_event(EV_FRAME);
        if (frameError && !prev_fe) take_event(EV_FERR);
        if (prev_fe) check("frameError_width", frameError, 0);
        if (overrun && !prev_ov) take_event(EV_OVR);
        if (prev_ov) check("overrun_width", overrun, 0);
      end
      prev_dr   = dataReceived;
      prev_fe   = frameError;
      prev_ov   = overrun;
      prev_held = {control, inputData};
    end
  end

  // Transmit-side monitor: decodes 8N1 bytes from tx.
  initial begin : tx_monitor
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge masterClock);
      if (reset && tx === 1'b0) begin
        repeat (BIT_CYCLES / 2) @(negedge masterClock);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYCLES) @(negedge masterClock);
          b[i] = tx;
        end
        repeat (BIT_CYCLES) @(negedge masterClock);
        stop = tx;
        if (tx_mon_en) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx_byte: got %0h expected none", b);
          end else begin
            check("tx_byte", b, exp_tx.pop_front());
            check("tx_stop", stop, 1);
          end
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge masterClock);
  endtask

  task automatic send_byte(logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge masterClock);
      rx = bits[i];
      repeat (BIT_CYCLES - 1) @(negedge masterClock);
    end
  endtask

  // Sends n bytes taken from the low n*8 bits, most significant byte first.
  task automatic send_seq(logic [63:0] bytes, int n);
    for (int i = n - 1; i >= 0; i--) send_byte(bytes[i*8 +: 8]);
  endtask

  task automatic pulse_clear();
    @(negedge masterClock);
    clearDR = 1'b1;
    @(negedge masterClock);
    clearDR = 1'b0;
  endtask

  // Raises clearDR for exactly the byteStb cycle, one cycle after UART dataReceived rises.
  task automatic clear_at_commit();
    logic prev;
    int   n;
    prev = 1'b1;
    n    = 0;
    while (n < 1000) begin
      @(negedge masterClock);
      if (dut.uart_dr && !prev) break;
      prev = dut.uart_dr;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL commit_wait: got no byte within %0d cycles expected one", n);
    end else begin
      @(negedge masterClock);
      clearDR = 1'b1;
      @(negedge masterClock);
      clearDR = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_control"}, control, 0);
    check({tag, "_inputData"}, inputData, 0);
    check({tag, "_dataReceived"}, dataReceived, 0);
    check({tag, "_transmitting"}, transmitting, 0);
    check({tag, "_frameError"}, frameError, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin : watchdog
    #(150000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    int n;
    reset = 1'b0; rx = 1'b1; clearDR = 1'b0;
    status = '0; outputData = '0; transmit = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    @(negedge masterClock);
    reset = 1'b1;
    idle(10);

    // Valid frame.
    push_ev(EV_FRAME, 8'h03, 16'h1234);
    send_seq(64'hA5_03_12_34_25, 5);
    idle(20);
    check("valid_dataReceived", dataReceived, 1);
    pulse_clear();
    idle(2);
    check("ack_dataReceived", dataReceived, 0);

    // Leading noise and a bad checksum, then a good frame.
    push_ev(EV_FERR, 8'h00, 16'h0000);
    send_seq(64'h00_FF, 2);
    send_seq(64'hA5_03_12_34_00, 5);
    idle(20);
    check("badsum_dataReceived", dataReceived, 0);
    push_ev(EV_FRAME, 8'h01, 16'h0000);
    send_seq(64'hA5_01_00_00_01, 5);
    idle(20);
    pulse_clear();

    // Timeout inside a frame, then a fresh frame.
    push_ev(EV_FERR, 8'h00, 16'h0000);
    send_seq(64'hA5_03_12, 3);
    idle(2200);
    push_ev(EV_FRAME, 8'h07, 16'hAA55);
    send_seq(64'hA5_07_AA_55_F8, 5);
    idle(20);
    pulse_clear();

    // Second frame while the first is still held: dropped with overrun.
    push_ev(EV_FRAME, 8'h03, 16'h1234);
    push_ev(EV_OVR, 8'h00, 16'h0000);
    send_seq(64'hA5_03_12_34_25, 5);
    idle(20);
    send_seq(64'hA5_01_00_00_01, 5);
    idle(20);
    check("overrun_held_control", control, 8'h03);
    check("overrun_held_data", inputData, 16'h1234);
    check("overrun_dataReceived", dataReceived, 1);
    pulse_clear();

    // Acknowledge in the commit cycle: second frame replaces the first, no overrun.
    push_ev(EV_FRAME, 8'h03, 16'h1234);
    push_ev(EV_FRAME, 8'h01, 16'h0000);
    send_seq(64'hA5_03_12_34_25, 5);
    idle(20);
    send_seq(64'hA5_01_00_00, 4);
    fork
      send_byte(8'h01);
      clear_at_commit();
    join
    idle(20);
    check("swap_dataReceived", dataReceived, 1);
    pulse_clear();

    // Transmit held high for 50k cycles: exactly one frame.
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h80);
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'hD1);
    check("tx_idle_transmitting", transmitting, 0);
    @(negedge masterClock);
    status = 8'h80; outputData = 16'hBEEF; transmit = 1'b1;
    @(negedge masterClock);
    check("tx_rise_transmitting", transmitting, 1);
    status = 8'h3C; outputData = 16'h0F0F;
    idle(49998);
    check("tx_hold_transmitting", transmitting, 1);
    check("tx_frame_bytes_left", exp_tx.size(), 0);
    transmit = 1'b0;
    idle(2);
    check("tx_release_transmitting", transmitting, 0);

    // Reset in the middle of both a transmit and a receive frame.
    tx_mon_en = 1'b0;
    @(negedge masterClock);
    status = 8'h11; outputData = 16'h2233; transmit = 1'b1;
    send_seq(64'hA5_44, 2);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    transmit = 1'b0;
    idle(10);
    reset = 1'b1;
    idle(500);
    tx_mon_en = 1'b1;
    push_ev(EV_FRAME, 8'h05, 16'h0FF0);
    send_seq(64'hA5_05_0F_F0_FA, 5);
    idle(20);
    check("post_reset_dataReceived", dataReceived, 1);

    // Drain anything still outstanding, bounded.
    n = 0;
    while ((exp_q.size() != 0 || exp_tx.size() != 0) && n < 5000) begin
      @(negedge masterClock);
      n++;
    end
    check("pending_events", exp_q.size(), 0);
    check("pending_tx_bytes", exp_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
